// File: rtl/matvec_pkg.sv
// Shared constants and types for the matrix-vector output requantiser.
package matvec_pkg;

  localparam int IN_W       = 28;
  localparam int OUT_W      = 14;
  localparam int VEC_LEN    = 8;
  localparam int FIFO_DEPTH = 8;

  // Element index width and the internal arithmetic width (one guard bit
  // above the input so the rounding addend can never overflow).
  localparam int ELEM_W    = $clog2(VEC_LEN);
  localparam int ACC_W     = IN_W + 1;
  localparam int SHIFT_W   = 5;
  localparam int MAX_SHIFT = 27;

  localparam int SAT_MAX = 8191;
  localparam int SAT_MIN = -8192;

  typedef struct packed {
    logic                    last;
    logic signed [OUT_W-1:0] data;
  } quant_entry_t;

  localparam int ENTRY_W = $bits(quant_entry_t);

  // Shift amounts above 27 would discard every magnitude bit; clamp them.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh);
    return (sh > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : sh;
  endfunction

endpackage

// File: rtl/matvec_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is presented combinationally whenever the FIFO is not
// empty; a write into an empty FIFO becomes visible on the following cycle.
module matvec_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic do_wr;
  logic do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // A read frees the head slot in the same cycle, so a write is allowed
  // when full as long as a read happens alongside it.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head entry, forced to zero when nothing is stored.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the storage array has no reset; the empty flag alone decides
  // whether its contents mean anything, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/matvec_out_quant.sv
// Output requantiser for the 8x8 matrix-vector multiplier: rounds, shifts,
// saturates and optionally rectifies each 28-bit dot product to 14 bits,
// then buffers results in a FWFT FIFO tagged with an end-of-vector flag.
module matvec_out_quant
  import matvec_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [4:0]         shift,
  input  logic               relu_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_last,
  input  logic               clear_flags,
  output logic               sat_flag
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

  // Vector position and per-vector configuration.
  logic [ELEM_W-1:0]  elem_q, elem_d;
  logic [SHIFT_W-1:0] cfg_shift_q, cfg_shift_d;
  logic               cfg_relu_q, cfg_relu_d;

  // Stage-1 pipe register.
  logic               pipe_valid_q, pipe_valid_d;
  quant_entry_t       pipe_entry_q, pipe_entry_d;
  logic               pipe_sat_q, pipe_sat_d;

  // Sticky saturation flag and post-reset ready enable.
  logic               sat_flag_q, sat_flag_d;
  logic               ready_en_q, ready_en_d;

  // Datapath intermediates.
  logic                     accept;
  logic                     first_elem;
  logic                     last_elem;
  logic [SHIFT_W-1:0]       eff_shift;
  logic                     eff_relu;
  logic signed [ACC_W-1:0]  acc_in;
  logic signed [ACC_W-1:0]  round_add;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  quant;
  logic                     sat_hit;

  // FIFO interface.
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  quant_entry_t       fifo_head;

  // Credit check: the pipe entry is already committed to the FIFO, so it
  // counts against free space. This guarantees the FIFO never overflows.
  assign in_ready = ready_en_q &&
                    ((fifo_count + CNT_W'(pipe_valid_q)) < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;

  assign first_elem = (elem_q == '0);
  assign last_elem  = (elem_q == ELEM_W'(VEC_LEN - 1));

  // Element 0 uses the live config inputs, the rest of the vector uses the
  // values captured when element 0 was accepted.
  assign eff_shift = first_elem ? clamp_shift(shift) : cfg_shift_q;
  assign eff_relu  = first_elem ? relu_en : cfg_relu_q;

  // Round-half-up, arithmetic shift, saturate, then optional ReLU.
  // NOTE: every variable in a combinational block gets a value on every
  // path (defaults first); a missed branch would otherwise infer a latch.
  always_comb begin
    acc_in    = ACC_W'(signed'(in_data));
    round_add = '0;
    if (eff_shift != '0) round_add = ACC_W'(1) <<< (eff_shift - 1'b1);
    rounded   = acc_in + round_add;
    shifted   = rounded >>> eff_shift;
    sat_hit   = 1'b0;
    quant     = shifted[OUT_W-1:0];
    if (shifted > SAT_HI) begin
      quant   = SAT_HI[OUT_W-1:0];
      sat_hit = 1'b1;
    end else if (shifted < SAT_LO) begin
      quant   = SAT_LO[OUT_W-1:0];
      sat_hit = 1'b1;
    end
    if (eff_relu && quant[OUT_W-1]) quant = '0;
  end

  // Next-state for counter, config latch, pipe register and sticky flag.
  always_comb begin
    elem_d       = elem_q;
    cfg_shift_d  = cfg_shift_q;
    cfg_relu_d   = cfg_relu_q;
    pipe_valid_d = accept;
    pipe_entry_d = pipe_entry_q;
    pipe_sat_d   = accept && sat_hit;
    ready_en_d   = 1'b1;

    if (accept) begin
      elem_d            = last_elem ? '0 : elem_q + 1'b1;
      pipe_entry_d.last = last_elem;
      pipe_entry_d.data = quant;
      if (first_elem) begin
        cfg_shift_d = eff_shift;
        cfg_relu_d  = eff_relu;
      end
    end

    // Set has priority over clear so a saturation is never lost.
    sat_flag_d = sat_flag_q;
    if (clear_flags)                 sat_flag_d = 1'b0;
    if (pipe_valid_q && pipe_sat_q)  sat_flag_d = 1'b1;
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elem_q       <= '0;
      cfg_shift_q  <= '0;
      cfg_relu_q   <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_entry_q <= '0;
      pipe_sat_q   <= 1'b0;
      sat_flag_q   <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      elem_q       <= elem_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_relu_q   <= cfg_relu_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_entry_q <= pipe_entry_d;
      pipe_sat_q   <= pipe_sat_d;
      sat_flag_q   <= sat_flag_d;
      ready_en_q   <= ready_en_d;
    end
  end

  matvec_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (pipe_valid_q),
    .wr_data (pipe_entry_q),
    .rd_en   (out_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head.data;
  assign out_last  = fifo_head.last;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_matvec_out_quant.sv
// Self-checking bench for matvec_out_quant: scoreboard of expected outputs
// filled at accept time and drained by an output monitor.
module tb_matvec_out_quant;
  import matvec_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic [4:0]              shift;
  logic                    relu_en;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;
  logic                    clear_flags;
  logic                    sat_flag;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic                    last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   tb_elem = 0;

  always #5 clk = ~clk;

  matvec_out_quant dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .shift       (shift),
    .relu_en     (relu_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .clear_flags (clear_flags),
    .sat_flag    (sat_flag)
  );

  // Reference requantiser using floor division rather than shifts.
  function automatic int model_q(input int d, input int sh, input bit relu);
    longint dv, v, q;
    int s;
    s  = (sh > 27) ? 27 : sh;
    dv = longint'(1) << s;
    v  = longint'(d) + ((s > 0) ? dv / 2 : 0);
    if (v >= 0) q = v / dv;
    else        q = -((-v + dv - 1) / dv);
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction

  task automatic push_exp(input int e);
    exp_t x;
    x.data = OUT_W'(e);
    x.last = (tb_elem == VEC_LEN - 1);
    exp_q.push_back(x);
    tb_elem = (tb_elem + 1) % VEC_LEN;
  endtask

  // Output monitor: every handshake pops and compares one expected entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got data=%0d last=%0b, required no output",
                 out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.data || out_last !== mon_e.last) begin
          errors++;
          $display("FAIL scoreboard: got data=%0d last=%0b, required data=%0d last=%0b",
                   out_data, out_last, mon_e.data, mon_e.last);
        end
      end
    end
  end

  // Offer one word; push its expected result on the accepting cycle.
  task automatic send(input int d, input int e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = IN_W'(d);
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: word %0d not accepted in 50 cycles, required accept", d);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    in_valid    = 1'b0;
    in_data     = '0;
    clear_flags = 1'b0;
    shift       = '0;
    relu_en     = 1'b0;
    out_ready   = 1'b1;
    reset_n     = 1'b0;
    exp_q.delete();
    tb_elem = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b, required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid_last: got %0b/%0b, required 0/0", out_valid, out_last);
    end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0d, required 0", out_data); end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_sat_flag: got %0b, required 0", sat_flag); end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %0b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    do_reset();
    send(5, 5);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_c1: out_valid %0b, required 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_c2: out_valid %0b, required 1", out_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_saturation();
    bit seen;
    do_reset();
    send(100, 100);
    send(-100, -100);
    send(8191, 8191);
    drain();
    @(negedge clk);
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_edge_8191: flag %0b, required 0", sat_flag); end
    @(posedge clk); #1;
    send(8192, 8191);
    send(-8193, -8192);
    drain();
    @(negedge clk);
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %0b, required 1", sat_flag); end
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
    @(negedge clk);
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %0b, required 0", sat_flag); end
    // Saturation arriving while clear is held must still set the flag.
    @(posedge clk); #1 clear_flags = 1'b1;
    send(9000, 8191);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= (sat_flag === 1'b1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL sat_set_wins: flag never 1, required 1"); end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear_held: got %0b, required 0", sat_flag); end
    @(posedge clk); #1 clear_flags = 1'b0;
    drain();
  endtask

  task automatic test_rounding();
    do_reset();
    shift = 5'd4;
    send(24, 2);
    send(-24, -1);
    send(23, 1);
    send(8, 1);
    drain();
  endtask

  task automatic test_relu();
    do_reset();
    relu_en = 1'b1;
    send(-500, 0);
    send(500, 500);
    send(-8193, 0);
    drain();
    @(negedge clk);
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL relu_sat_flag: got %0b, required 1", sat_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_config_latch();
    do_reset();
    send(100, 100);
    send(101, 101);
    send(102, 102);
    shift   = 5'd2;
    relu_en = 1'b1;
    send(103, 103);
    send(-50, -50);
    send(105, 105);
    send(106, 106);
    send(107, 107);
    send(42, 11);
    send(-8, 0);
    drain();
  endtask

  task automatic test_backpressure();
    int w[10];
    int idx;
    do_reset();
    for (int k = 0; k < 10; k++) w[k] = k * 1500 - 4000;
    idx       = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      in_data = IN_W'(w[idx]);
      @(negedge clk);
      if (in_ready) begin
        push_exp(model_q(w[idx], 0, 1'b0));
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (idx != 8) begin errors++; $display("FAIL bp_accepts: got %0d, required 8", idx); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== OUT_W'(model_q(w[0], 0, 1'b0)) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_head_stable: got valid=%0b data=%0d last=%0b, required 1/%0d/0",
               out_valid, out_data, out_last, model_q(w[0], 0, 1'b0));
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && idx < 10; cyc++) begin
      in_data = IN_W'(w[idx]);
      @(negedge clk);
      if (in_ready) begin
        push_exp(model_q(w[idx], 0, 1'b0));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 10) begin errors++; $display("FAIL bp_remaining: accepted %0d, required 10", idx); end
    drain();
  endtask

  task automatic test_back_to_back();
    int d;
    int acc;
    do_reset();
    shift    = 5'd3;
    acc      = 0;
    d        = int'($urandom) >>> 4;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      in_data = IN_W'(d);
      @(negedge clk);
      if (in_ready) begin
        push_exp(model_q(d, 3, 1'b0));
        acc++;
        d = int'($urandom) >>> 4;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (acc != 16) begin errors++; $display("FAIL b2b_throughput: %0d accepts in 16 cycles, required 16", acc); end
    // Random output stalls with ReLU taking effect at the next vector start.
    relu_en = 1'b1;
    acc     = 0;
    for (int cyc = 0; cyc < 400 && acc < 40; cyc++) begin
      in_data   = IN_W'(d);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        push_exp(model_q(d, 3, 1'b1));
        acc++;
        d = int'($urandom) >>> 4;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 40) begin errors++; $display("FAIL b2b_random: accepted %0d, required 40", acc); end
    drain();
  endtask

  task automatic test_reset_mid_vector();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i * 10 + 1, i * 10 + 1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: out_valid %0b, required 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_async: valid/ready %0b/%0b, required 0/0", out_valid, in_ready);
    end
    exp_q.delete();
    tb_elem = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(-(i * 7), -(i * 7));
    drain();
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    shift       = '0;
    relu_en     = 1'b0;
    out_ready   = 1'b1;
    clear_flags = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_saturation();
    test_rounding();
    test_relu();
    test_config_latch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_vector();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
